// File: rtl/nf_axis_rx_packer.sv
// Byte-stream MAC receiver that packs frames into W-bit AXI-Stream beats.
// Frames are held in a commit/rewind FIFO and released only when complete and good.
module nf_axis_rx_packer #(
  parameter int          C_M_AXIS_DATA_WIDTH  = 256,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0]  C_DEFAULT_SRC_PORT   = 8'h01,
  parameter logic [7:0]  C_DEFAULT_DST_PORT   = 8'h00,
  parameter int          C_DATA_DEPTH         = 256,
  parameter int          C_MAX_PKTS           = 16
) (
  input  logic                             axi_aclk,
  input  logic                             axi_aresetn,
  input  logic [7:0]                       s_rx_tdata,
  input  logic                             s_rx_tvalid,
  input  logic                             s_rx_tlast,
  input  logic                             s_rx_tuser,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [31:0]                      pkt_count,
  output logic [31:0]                      drop_count
);

  localparam int W  = C_M_AXIS_DATA_WIDTH;
  localparam int B  = W / 8;
  localparam int LB = $clog2(B);
  localparam int TU = C_M_AXIS_TUSER_WIDTH;
  localparam int DA = $clog2(C_DATA_DEPTH);
  localparam int LA = $clog2(C_MAX_PKTS);
  localparam logic [DA:0]  D_ONE = 1;
  localparam logic [LA:0]  L_ONE = 1;
  localparam logic [B-1:0] ONE_B = 1;

  typedef enum logic [1:0] {R_IDLE, R_RECV, R_DROP} rx_state_t;
  typedef enum logic {T_IDLE, T_SEND} tx_state_t;

  logic [W-1:0]  dmem [C_DATA_DEPTH];
  logic [15:0]   lmem [C_MAX_PKTS];
  logic [DA:0]   wr_ptr, cm_ptr, rd_ptr;
  logic [LA:0]   lf_wr, lf_wr_q, lf_rd;
  logic [W-1:0]  acc, acc_nxt;
  logic [15:0]   len, left;
  logic [LB-1:0] lane;
  rx_state_t     rx_state, rx_next;
  tx_state_t     tx_state, tx_next;

  logic byte_ok, need_wr, d_full, l_full, ovf, commit, drop;

  assign lane    = len[LB-1:0];
  assign byte_ok = s_rx_tvalid && (rx_state != R_DROP);
  assign need_wr = byte_ok && ((lane == LB'(B - 1)) || s_rx_tlast);
  assign acc_nxt = acc | (W'(s_rx_tdata) << {lane, 3'b000});
  assign d_full  = (wr_ptr[DA] != rd_ptr[DA]) &&
                   (wr_ptr[DA-1:0] == rd_ptr[DA-1:0]);
  assign l_full  = (lf_wr[LA] != lf_rd[LA]) &&
                   (lf_wr[LA-1:0] == lf_rd[LA-1:0]);
  assign ovf     = (byte_ok && len == 16'hFFFF) || (need_wr && d_full);
  assign commit  = byte_ok && s_rx_tlast && !ovf &&
                   !s_rx_tuser && !l_full;
  assign drop    = byte_ok && (ovf ||
                   (s_rx_tlast && (s_rx_tuser || l_full)));

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:
        if (s_rx_tvalid && !s_rx_tlast)
          rx_next = ovf ? R_DROP : R_RECV;
      R_RECV:
        if (s_rx_tvalid) begin
          if (s_rx_tlast)  rx_next = R_IDLE;
          else if (ovf)    rx_next = R_DROP;
        end
      R_DROP:
        if (s_rx_tvalid && s_rx_tlast) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (need_wr && !ovf) dmem[wr_ptr[DA-1:0]] <= acc_nxt;
    if (commit)          lmem[lf_wr[LA-1:0]]  <= len + 16'd1;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rx_state   <= R_IDLE;
      acc        <= '0;
      len        <= '0;
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      lf_wr      <= '0;
      lf_wr_q    <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      rx_state <= rx_next;
      lf_wr_q  <= lf_wr;
      if (byte_ok) begin
        if (drop || s_rx_tlast) begin
          acc <= '0;
          len <= '0;
        end else begin
          acc <= need_wr ? '0 : acc_nxt;
          len <= len + 16'd1;
        end
      end
      // a drop rewinds every uncommitted word of the frame
      if (drop)         wr_ptr <= cm_ptr;
      else if (need_wr) wr_ptr <= wr_ptr + D_ONE;
      if (commit) begin
        cm_ptr    <= wr_ptr + D_ONE;
        lf_wr     <= lf_wr + L_ONE;
        pkt_count <= pkt_count + 32'd1;
      end
      if (drop) drop_count <= drop_count + 32'd1;
    end
  end

  logic          lf_avail, beat_done, load_first, load_next, go_idle;
  logic          is_last;
  logic [15:0]   first_len, src;
  logic [B-1:0]  strb_v;
  logic [TU-1:0] tuser_v;

  // delayed write pointer gives the fixed two-cycle commit-to-valid latency
  assign lf_avail   = lf_wr_q != lf_rd;
  assign beat_done  = m_axis_tvalid && m_axis_tready;
  assign load_first = lf_avail &&
                      (tx_state == T_IDLE || (beat_done && m_axis_tlast));
  assign load_next  = beat_done && !m_axis_tlast;
  assign go_idle    = beat_done && m_axis_tlast && !lf_avail;
  assign first_len  = lmem[lf_rd[LA-1:0]];

  always_comb begin
    src     = load_first ? first_len : left;
    is_last = {1'b0, src} <= 17'(B);
    strb_v  = '1;
    if (is_last && src[LB-1:0] != '0)
      strb_v = (ONE_B << src[LB-1:0]) - ONE_B;
    tuser_v = '0;
    if (load_first)
      tuser_v[31:0] = {C_DEFAULT_DST_PORT, C_DEFAULT_SRC_PORT, first_len};
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (lf_avail) tx_next = T_SEND;
      T_SEND:  if (go_idle)  tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      tx_state      <= T_IDLE;
      rd_ptr        <= '0;
      lf_rd         <= '0;
      left          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (load_first || load_next) begin
        m_axis_tdata  <= dmem[rd_ptr[DA-1:0]];
        m_axis_tstrb  <= strb_v;
        m_axis_tuser  <= tuser_v;
        m_axis_tlast  <= is_last;
        m_axis_tvalid <= 1'b1;
        rd_ptr        <= rd_ptr + D_ONE;
        left          <= is_last ? 16'd0 : src - 16'(B);
        if (load_first) lf_rd <= lf_rd + L_ONE;
      end else if (go_idle) begin
        m_axis_tdata  <= '0;
        m_axis_tstrb  <= '0;
        m_axis_tuser  <= '0;
        m_axis_tlast  <= 1'b0;
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nf_axis_rx_packer.sv
// Directed bench for nf_axis_rx_packer: packing, drops, stalls, latency, reset.
// Two instances share the byte stream; sel picks which one sees it.
module tb_nf_axis_rx_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic rx_last = 1'b0;
  logic rx_user = 1'b0;
  logic sel = 1'b0;
  logic tready = 1'b0;

  logic [255:0] d_a, d_b, o_d;
  logic [31:0]  s_a, s_b, o_s;
  logic [127:0] u_a, u_b, o_u;
  logic v_a, v_b, o_v, l_a, l_b, o_l;
  logic [31:0] pc_a, pc_b, dc_a, dc_b, o_pc, o_dc;

  always #5 clk = ~clk;

  nf_axis_rx_packer dut_a (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_rx_tdata(rx_data), .s_rx_tvalid(rx_valid & ~sel),
    .s_rx_tlast(rx_last), .s_rx_tuser(rx_user),
    .m_axis_tdata(d_a), .m_axis_tstrb(s_a), .m_axis_tuser(u_a),
    .m_axis_tvalid(v_a), .m_axis_tready(tready & ~sel),
    .m_axis_tlast(l_a), .pkt_count(pc_a), .drop_count(dc_a)
  );

  nf_axis_rx_packer #(.C_DATA_DEPTH(4)) dut_b (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_rx_tdata(rx_data), .s_rx_tvalid(rx_valid & sel),
    .s_rx_tlast(rx_last), .s_rx_tuser(rx_user),
    .m_axis_tdata(d_b), .m_axis_tstrb(s_b), .m_axis_tuser(u_b),
    .m_axis_tvalid(v_b), .m_axis_tready(tready & sel),
    .m_axis_tlast(l_b), .pkt_count(pc_b), .drop_count(dc_b)
  );

  assign o_d  = sel ? d_b : d_a;
  assign o_s  = sel ? s_b : s_a;
  assign o_u  = sel ? u_b : u_a;
  assign o_v  = sel ? v_b : v_a;
  assign o_l  = sel ? l_b : l_a;
  assign o_pc = sel ? pc_b : pc_a;
  assign o_dc = sel ? dc_b : dc_a;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
    int           cyc;
  } beat_t;

  beat_t beats[$];
  int cyc = 0;
  int n_chk = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && o_v && tready)
      beats.push_back('{d: o_d, s: o_s, u: o_u, l: o_l, cyc: cyc});

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_word(input int base, input int n,
                                            input int w);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 32; k++)
      if (w * 32 + k < n) r[8*k +: 8] = 8'(base + w * 32 + k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input int base, input bit bad);
    for (int i = 0; i < n; i++) begin
      rx_data  = 8'(base + i);
      rx_valid = 1'b1;
      rx_last  = (i == n - 1);
      rx_user  = bad && (i == n - 1);
      tick();
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_user  = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && beats.size() < n; i++) tick();
    chk(tag, beats.size(), n);
  endtask

  int bad_stall;
  logic [255:0] sd;
  logic [31:0]  ss;
  logic [127:0] su;
  logic         sl;

  initial begin
    repeat (3) tick();
    chk("rst_valid", o_v, 0);
    chk("rst_data", o_d, 0);
    chk("rst_strb", o_s, 0);
    chk("rst_user", o_u, 0);
    chk("rst_last", o_l, 0);
    chk("rst_cnt", {o_pc, o_dc}, 0);
    rst_n = 1'b1;
    tick();

    // 64-byte frame, latency and back-to-back
    tready = 1'b1;
    send_frame(64, 0, 0);
    chk("lat_c0", o_v, 0);
    tick();
    chk("lat_c1", o_v, 0);
    tick();
    chk("lat_c2", o_v, 1);
    wait_beats("f64_n", 2, 40);
    if (beats.size() >= 2) begin
      chk("f64_b0_lo", beats[0].d[7:0], 8'h00);
      chk("f64_b0_d", beats[0].d, exp_word(0, 64, 0));
      chk("f64_b1_d", beats[1].d, exp_word(0, 64, 1));
      chk("f64_b0_u", beats[0].u, 128'h0001_0040);
      chk("f64_b1_u", beats[1].u, 0);
      chk("f64_b0_s", beats[0].s, 32'hFFFF_FFFF);
      chk("f64_b1_s", beats[1].s, 32'hFFFF_FFFF);
      chk("f64_lasts", {beats[0].l, beats[1].l}, 2'b01);
      chk("f64_gap", beats[1].cyc - beats[0].cyc, 1);
    end
    chk("f64_pkt", o_pc, 1);
    beats.delete();

    // 65-byte frame: one-byte tail beat
    send_frame(65, 0, 0);
    wait_beats("f65_n", 3, 40);
    if (beats.size() >= 3) begin
      chk("f65_u", beats[0].u, 128'h0001_0041);
      chk("f65_b1_d", beats[1].d, exp_word(0, 65, 1));
      chk("f65_b2_s", beats[2].s, 32'h0000_0001);
      chk("f65_b2_lo", beats[2].d[7:0], 8'h40);
      chk("f65_b2_d", beats[2].d, 256'h40);
      chk("f65_lasts", {beats[0].l, beats[1].l, beats[2].l}, 3'b001);
    end
    beats.delete();

    // good, bad, good
    send_frame(10, 8'h20, 0);
    send_frame(20, 8'h30, 1);
    send_frame(40, 8'h50, 0);
    wait_beats("gbg_n", 3, 40);
    repeat (10) tick();
    chk("gbg_n_final", beats.size(), 3);
    if (beats.size() >= 3) begin
      chk("gbg_b0_u", beats[0].u, 128'h0001_000A);
      chk("gbg_b0_s", beats[0].s, 32'h0000_03FF);
      chk("gbg_b0_l", beats[0].l, 1);
      chk("gbg_b0_d", beats[0].d, exp_word(8'h20, 10, 0));
      chk("gbg_b1_u", beats[1].u, 128'h0001_0028);
      chk("gbg_b2_s", beats[2].s, 32'h0000_00FF);
      chk("gbg_b2_d", beats[2].d, exp_word(8'h50, 40, 1));
    end
    chk("gbg_pkt", o_pc, 4);
    chk("gbg_drop", o_dc, 1);
    beats.delete();

    // two frames, output stalled mid-packet
    tready = 1'b0;
    send_frame(64, 8'h10, 0);
    send_frame(64, 8'h90, 0);
    for (int i = 0; i < 20 && !o_v; i++) tick();
    chk("stall_v", o_v, 1);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    sd = o_d; ss = o_s; su = o_u; sl = o_l;
    bad_stall = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!o_v || o_d !== sd || o_s !== ss || o_u !== su || o_l !== sl)
        bad_stall++;
    end
    chk("stall_stable", bad_stall, 0);
    chk("stall_n", beats.size(), 1);
    tready = 1'b1;
    wait_beats("stall_all", 4, 40);
    if (beats.size() >= 4) begin
      chk("stall_b0_d", beats[0].d, exp_word(8'h10, 64, 0));
      chk("stall_b1_d", beats[1].d, exp_word(8'h10, 64, 1));
      chk("stall_b2_d", beats[2].d, exp_word(8'h90, 64, 0));
      chk("stall_b2_u", beats[2].u, 128'h0001_0040);
      chk("stall_b3_d", beats[3].d, exp_word(8'h90, 64, 1));
      chk("stall_lasts",
          {beats[0].l, beats[1].l, beats[2].l, beats[3].l}, 4'b0101);
    end
    chk("stall_pkt", o_pc, 6);
    beats.delete();

    // depth-4 instance: overflow drop, then a fitting frame
    sel = 1'b1;
    tready = 1'b0;
    send_frame(200, 0, 0);
    repeat (3) tick();
    chk("ovf_drop", o_dc, 1);
    chk("ovf_pkt", o_pc, 0);
    chk("ovf_v", o_v, 0);
    tready = 1'b1;
    send_frame(32, 8'h60, 0);
    wait_beats("d4_n", 1, 20);
    repeat (5) tick();
    chk("d4_n_final", beats.size(), 1);
    if (beats.size() >= 1) begin
      chk("d4_len", beats[0].u[15:0], 16'd32);
      chk("d4_u", beats[0].u, 128'h0001_0020);
      chk("d4_s", beats[0].s, 32'hFFFF_FFFF);
      chk("d4_l", beats[0].l, 1);
      chk("d4_d", beats[0].d, exp_word(8'h60, 32, 0));
    end
    beats.delete();
    sel = 1'b0;
    tready = 1'b0;

    // reset while sending
    send_frame(100, 8'h01, 0);
    for (int i = 0; i < 20 && !o_v; i++) tick();
    chk("rs_v_pre", o_v, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_valid", o_v, 0);
    chk("rs_data", o_d, 0);
    chk("rs_strb", o_s, 0);
    chk("rs_user", o_u, 0);
    chk("rs_last", o_l, 0);
    chk("rs_cnt", {o_pc, o_dc}, 0);
    tick();
    rst_n = 1'b1;
    beats.delete();
    tready = 1'b1;
    send_frame(1, 8'hA5, 0);
    wait_beats("rs1_n", 1, 20);
    repeat (10) tick();
    chk("rs1_n_final", beats.size(), 1);
    if (beats.size() >= 1) begin
      chk("rs1_d", beats[0].d, 256'hA5);
      chk("rs1_s", beats[0].s, 32'h0000_0001);
      chk("rs1_l", beats[0].l, 1);
      chk("rs1_u", beats[0].u, 128'h0001_0001);
    end
    chk("rs1_pkt", o_pc, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/nf_axis_rx_packer.md
NF_AXIS_RX_PACKER -- requirements
Module: nf_axis_rx_packer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- C_M_AXIS_DATA_WIDTH, 256, output data width W; a power of 2 from 64 to 256; B = W/8 bytes per beat.
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width; at least 32.
- C_DEFAULT_SRC_PORT, 8'h01, source-port tag.
- C_DEFAULT_DST_PORT, 8'h00, destination-port tag.
- C_DATA_DEPTH, 256, data FIFO depth in W-bit words; a power of 2.
- C_MAX_PKTS, 16, length FIFO depth in packets; a power of 2.

REQ-002 Ports (name, direction, width, meaning), one per line:
- axi_aclk, in, 1, the single clock.
- axi_aresetn, in, 1, asynchronous active-low reset.
- s_rx_tdata, in, 8, MAC receive byte.
- s_rx_tvalid, in, 1, byte valid; this input has no ready signal and the block cannot stall the MAC.
- s_rx_tlast, in, 1, last byte of the frame.
- s_rx_tuser, in, 1, bad-frame flag; sampled only with s_rx_tlast.
- m_axis_tdata, out, W, packed data.
- m_axis_tstrb, out, B, byte strobes.
- m_axis_tuser, out, C_M_AXIS_TUSER_WIDTH, packet metadata.
- m_axis_tvalid, out, 1, output beat valid.
- m_axis_tready, in, 1, downstream ready.
- m_axis_tlast, out, 1, last beat of the packet.
- pkt_count, out, 32, number of packets committed.
- drop_count, out, 32, number of packets dropped.

REQ-003 One clock; reset is asynchronous and active-low.

Function
REQ-004 Packing: byte i of a packet is placed in word floor(i/B), bits [8*(i mod B)+7 : 8*(i mod B)].
- A word is written to the data FIFO when its lane B-1 is filled or on s_rx_tlast.
- Unfilled lanes of a word are zero.

REQ-005 Receive FSM states: IDLE, RECV, DROP.
- IDLE -> RECV on a valid byte that is not last.
- RECV -> IDLE on a valid byte with s_rx_tlast.
- RECV -> DROP on an overflow condition.
- DROP -> IDLE on a valid byte with s_rx_tlast.
- A single-byte frame (valid with tlast while in IDLE) is handled as a complete packet.

REQ-006 Commit: on s_rx_tlast with s_rx_tuser=0 and no overflow in the frame:
- the data FIFO commit pointer advances to the write pointer;
- the byte length (16 bits) is pushed to the length FIFO;
- pkt_count increments.

REQ-007 A frame is dropped if any of the following occurs:
- s_rx_tuser=1 at tlast;
- the data FIFO is full when a word must be written;
- the length FIFO is full at tlast;
- the length exceeds 65535 bytes.

REQ-008 On a drop:
- the write pointer rewinds to the commit pointer;
- drop_count increments exactly once per frame;
- the remaining bytes of the frame are discarded in DROP.

REQ-009 Output FSM states: IDLE, SEND.
- IDLE -> SEND when the length FIFO is non-empty.
- SEND -> IDLE when the tlast beat is accepted.
- SEND -> SEND directly if another length entry is pending.

REQ-010 First beat tuser:
- [15:0] = byte length;
- [23:16] = C_DEFAULT_SRC_PORT;
- [31:24] = C_DEFAULT_DST_PORT;
- all remaining bits are 0.
- Every later beat of the packet carries tuser = 0.

REQ-011 tstrb: all ones except on the last beat, where it has the low (len mod B) bits set, or all ones if len mod B = 0.

REQ-012 Handshake: a beat transfers when m_axis_tvalid and m_axis_tready are both 1. While tvalid=1 and tready=0, tdata, tstrb, tuser and tlast are held stable; tvalid does not deassert before the transfer.

REQ-013 Latency: with the output side idle, m_axis_tvalid rises exactly 2 cycles after the cycle in which the committing tlast byte is sampled. At tready=1, back-to-back beats are delivered with no bubbles.

REQ-014 Simultaneous events:
- A commit and a read in the same cycle are both honoured.
- The full and empty flags use pointers that carry a wrap bit; pointers wrap modulo the depth.
- Readout never passes the commit pointer.

REQ-015 Counters wrap from 2^32-1 to 0.

Reset
REQ-016 While axi_aresetn=0:
- all FIFO pointers, pkt_count and drop_count are 0;
- both FSMs are in IDLE;
- m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb and m_axis_tuser are 0.

REQ-017 Reset mid-packet discards all buffered and partial data. The first valid byte after reset release starts a new packet.

Verification
REQ-018 The bench covers these scenarios (W=256, default parameters unless stated):
- 64-byte good frame with bytes 0x00..0x3F -> 2 beats; beat0 [7:0]=0x00; tuser[31:0]=0x0001_0040; tstrb=0xFFFFFFFF on both beats; tlast on beat1; pkt_count=1.
- 65-byte frame -> 3 beats; last-beat tstrb=0x00000001 with [7:0]=0x40.
- Good, bad (tuser=1 at tlast), good frames -> 2 output packets; pkt_count=2; drop_count=1.
- Two 64-byte frames with tready held 0 for 10 cycles mid-packet -> outputs stable while stalled, 4 beats total, no loss.
- C_DATA_DEPTH=4, tready=0, 200-byte frame -> dropped, drop_count=1; then a 32-byte frame with tready=1 -> delivered as 1 beat, tuser[15:0]=32.
- axi_aresetn pulsed low during SEND -> all outputs 0 within the same cycle; after release, a 1-byte frame yields 1 beat with tstrb=0x00000001 and tlast=1.
